// File: rtl/fifo_uart_tx.sv
// FIFO consumer drain: pops one byte at a time and sends it as an 8N1 UART frame.
// tx, read_event and busy are decoded from registered state only.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        Q_EMPTY,
  input  logic [7:0]  fifo_data,
  output logic        read_event,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frames_sent
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   frames_sent_q, frames_sent_d;
  logic          bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      frames_sent_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    frames_sent_d = frames_sent_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable && !Q_EMPTY) state_d = S_POP;
      end
      S_POP: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        shift_d = fifo_data;
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d         = '0;
          frames_sent_d = frames_sent_q + 16'd1;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    tx = 1'b1;
    unique case (1'b1)
      (state_q == S_START): tx = 1'b0;
      (state_q == S_DATA):  tx = shift_q[0];
      default:              tx = 1'b1;
    endcase
  end

  assign read_event  = (state_q == S_POP);
  assign busy        = (state_q != S_IDLE);
  assign frames_sent = frames_sent_q;

endmodule
